// File: rtl/cordic_sched.sv
// Round-robin scheduler that shares one CORDIC rotator between NCH channels.
// One operation is outstanding at a time: grant -> start pulse -> wait for the
// core (guarded by a watchdog) -> hold the response until it is accepted.
module cordic_sched #(
    parameter int BW  = 12,
    parameter int ABW = 10,
    parameter int NCH = 4,
    parameter int TMO = 32
) (
    input  logic                     clk_fs,
    input  logic                     rst,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH*BW-1:0]        req_I,
    input  logic [NCH*BW-1:0]        req_Q,
    input  logic [NCH*ABW-1:0]       req_phase,
    output logic                     core_start,
    output logic [BW-1:0]            core_I,
    output logic [BW-1:0]            core_Q,
    output logic [ABW-1:0]           core_phase,
    input  logic                     core_done,
    input  logic [BW-1:0]            core_Iout,
    input  logic [BW-1:0]            core_Qout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NCH)-1:0]   rsp_id,
    output logic [BW-1:0]            rsp_I,
    output logic [BW-1:0]            rsp_Q,
    output logic                     busy,
    output logic                     tmo_err
);

    localparam int IDW = $clog2(NCH);
    localparam int WDW = $clog2(TMO);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TMO - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  id_q;
    logic [BW-1:0]   op_i_q, op_q_q;
    logic [ABW-1:0]  op_ph_q;
    logic [BW-1:0]   res_i_q, res_q_q;
    logic [WDW-1:0]  wd_q;
    logic            tmo_q;

    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  cand;
    logic            wd_expired;

    // Channel index a+b, wrapped into 0..NCH-1 (b is at most NCH).
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return IDW'(s);
    endfunction

    // Round-robin search: first valid channel at or after ptr, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < NCH; i++) begin
            cand = wrap_add(ptr_q, i);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Timeout fires in the WAIT cycle where the count has reached TMO-1 with no done.
    assign wd_expired = (wd_q == WD_LAST) && !core_done;

    // State register.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; core_done only matters while waiting.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (core_done) begin
                    state_d = S_RESP;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready is held low while reset is asserted.
    always_comb begin
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (grant_any && !rst) begin
                    req_ready = NCH'(1) << grant_idx;
                end
            end
            S_ISSUE: core_start = 1'b1;
            S_WAIT:  ;
            S_RESP:  rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture on grant, watchdog, result capture, timeout pulse.
    always_ff @(posedge clk_fs) begin
        if (rst) begin
            ptr_q   <= '0;
            id_q    <= '0;
            op_i_q  <= '0;
            op_q_q  <= '0;
            op_ph_q <= '0;
            res_i_q <= '0;
            res_q_q <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        op_i_q  <= req_I[grant_idx*BW +: BW];
                        op_q_q  <= req_Q[grant_idx*BW +: BW];
                        op_ph_q <= req_phase[grant_idx*ABW +: ABW];
                        id_q    <= grant_idx;
                        ptr_q   <= wrap_add(grant_idx, 1);
                    end
                end
                S_ISSUE: wd_q <= '0;
                S_WAIT: begin
                    if (core_done) begin
                        res_i_q <= core_Iout;
                        res_q_q <= core_Qout;
                    end else if (wd_expired) begin
                        tmo_q <= 1'b1;
                    end else begin
                        wd_q <= wd_q + WDW'(1);
                    end
                end
                S_RESP:  ;
                default: ;
            endcase
        end
    end

    assign core_I     = op_i_q;
    assign core_Q     = op_q_q;
    assign core_phase = op_ph_q;
    assign rsp_id     = id_q;
    assign rsp_I      = res_i_q;
    assign rsp_Q      = res_q_q;
    assign tmo_err    = tmo_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Directed bench for cordic_sched: the bench plays the CORDIC core and the
// response sink, with hand-computed expectations for each scenario.
module tb_cordic_sched;

    localparam int BW  = 12;
    localparam int ABW = 10;
    localparam int NCH = 4;
    localparam int TMO = 32;

    logic                 clk_fs = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       req_valid;
    logic [NCH-1:0]       req_ready;
    logic [NCH*BW-1:0]    req_I;
    logic [NCH*BW-1:0]    req_Q;
    logic [NCH*ABW-1:0]   req_phase;
    logic                 core_start;
    logic [BW-1:0]        core_I;
    logic [BW-1:0]        core_Q;
    logic [ABW-1:0]       core_phase;
    logic                 core_done;
    logic [BW-1:0]        core_Iout;
    logic [BW-1:0]        core_Qout;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [BW-1:0]        rsp_I;
    logic [BW-1:0]        rsp_Q;
    logic                 busy;
    logic                 tmo_err;

    int vectors     = 0;
    int miscompares = 0;
    int start_cnt   = 0;

    cordic_sched #(.BW(BW), .ABW(ABW), .NCH(NCH), .TMO(TMO)) dut (
        .clk_fs     (clk_fs),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_I      (req_I),
        .req_Q      (req_Q),
        .req_phase  (req_phase),
        .core_start (core_start),
        .core_I     (core_I),
        .core_Q     (core_Q),
        .core_phase (core_phase),
        .core_done  (core_done),
        .core_Iout  (core_Iout),
        .core_Qout  (core_Qout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_I      (rsp_I),
        .rsp_Q      (rsp_Q),
        .busy       (busy),
        .tmo_err    (tmo_err)
    );

    always #5 clk_fs = ~clk_fs;

    // Count start pulses, sampled on the falling edge.
    always @(negedge clk_fs) begin
        if (core_start === 1'b1) start_cnt++;
    end

    // Advance one clock; inputs are driven 2 time units after the edge.
    task automatic tick();
        @(posedge clk_fs);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        tick();
        tick();
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++; if ({core_start, rsp_valid, busy, tmo_err} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctrl: start/valid/busy/tmo got %b want 0000", {core_start, rsp_valid, busy, tmo_err}); end
        vectors++; if ({core_I, core_Q, core_phase} !== '0) begin miscompares++; $display("FAIL reset_core_ops: got %h want 0", {core_I, core_Q, core_phase}); end
        vectors++; if ({rsp_id, rsp_I, rsp_Q} !== '0) begin miscompares++; $display("FAIL reset_rsp: got %h want 0", {rsp_id, rsp_I, rsp_Q}); end
        rst = 1'b0;
        req_valid = '0;
        tick();
        #1;
        vectors++; if ({req_ready, busy, rsp_valid, core_start} !== 7'b0) begin miscompares++; $display("FAIL reset_release: got %b want 0", {req_ready, busy, rsp_valid, core_start}); end
        $display("reset: outputs checked during and after reset");
    endtask

    task automatic test_single();
        int s0;
        req_I[2*BW +: BW]      = 12'h064;
        req_Q[2*BW +: BW]      = 12'hFCE;
        req_phase[2*ABW +: ABW] = 10'd256;
        req_valid = 4'b0100;
        #1;
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant: req_ready %b want 0100", req_ready); end
        s0 = start_cnt;
        tick();
        req_valid = '0;
        #1;
        vectors++; if (core_start !== 1'b1 || req_ready !== 4'b0000 || busy !== 1'b1) begin miscompares++; $display("FAIL single_issue: start=%b ready=%b busy=%b want 1,0000,1", core_start, req_ready, busy); end
        vectors++; if (core_I !== 12'h064 || core_Q !== 12'hFCE || core_phase !== 10'd256) begin miscompares++; $display("FAIL single_ops: I=%h Q=%h ph=%h want 064 FCE 100", core_I, core_Q, core_phase); end
        tick();
        #1;
        vectors++; if (core_start !== 1'b0 || core_I !== 12'h064) begin miscompares++; $display("FAIL single_wait: start=%b I=%h want 0 064", core_start, core_I); end
        tick();
        tick();
        core_done = 1'b1;
        core_Iout = 12'h032;
        core_Qout = 12'h064;
        #1;
        vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_early_rsp: rsp_valid %b want 0", rsp_valid); end
        tick();
        core_done = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin miscompares++; $display("FAIL single_rsp: valid=%b id=%0d want 1 2", rsp_valid, rsp_id); end
        vectors++; if (rsp_I !== 12'h032 || rsp_Q !== 12'h064) begin miscompares++; $display("FAIL single_rsp_data: I=%h Q=%h want 032 064", rsp_I, rsp_Q); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_done: valid=%b busy=%b want 0 0", rsp_valid, busy); end
        vectors++; if (start_cnt - s0 !== 1) begin miscompares++; $display("FAIL single_start_count: got %0d want 1", start_cnt - s0); end
        $display("single: ch2 I=100 Q=-50 ph=256 -> rsp id=%0d I=%0d Q=%0d", rsp_id, $signed(rsp_I), $signed(rsp_Q));
    endtask

    task automatic test_round_robin();
        int exp;
        logic [NCH-1:0] exp_oh;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            req_I[k*BW +: BW]       = BW'(k*16 + 1);
            req_Q[k*BW +: BW]       = BW'(k*16 + 2);
            req_phase[k*ABW +: ABW] = ABW'(k*64 + 3);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp = g % NCH;
            exp_oh = NCH'(1) << exp;
            vectors++; if (req_ready !== exp_oh) begin miscompares++; $display("FAIL rr_grant%0d: req_ready %b want %b", g, req_ready, exp_oh); end
            tick();
            #1;
            vectors++; if (core_start !== 1'b1 || core_I !== BW'(exp*16 + 1) || core_phase !== ABW'(exp*64 + 3)) begin miscompares++; $display("FAIL rr_issue%0d: start=%b I=%h ph=%h want 1 %h %h", g, core_start, core_I, core_phase, BW'(exp*16 + 1), ABW'(exp*64 + 3)); end
            tick();
            core_done = 1'b1;
            core_Iout = BW'(exp + 5);
            core_Qout = BW'(exp + 9);
            #1;
            tick();
            core_done = 1'b0;
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_I !== BW'(exp + 5) || req_ready !== 4'b0000) begin miscompares++; $display("FAIL rr_rsp%0d: valid=%b id=%0d I=%h ready=%b want 1 %0d %h 0000", g, rsp_valid, rsp_id, rsp_I, req_ready, exp, BW'(exp + 5)); end
            $display("round_robin: grant %0d -> ch%0d", g, rsp_id);
            tick();
            #1;
        end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL bp_grant: req_ready %b want 0010", req_ready); end
        tick();
        #1;
        vectors++; if (core_start !== 1'b1 || core_I !== 12'h011) begin miscompares++; $display("FAIL bp_issue: start=%b I=%h want 1 011", core_start, core_I); end
        tick();
        core_done = 1'b1;
        core_Iout = 12'h5A5;
        core_Qout = 12'hA5A;
        #1;
        tick();
        core_done = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || rsp_I !== 12'h5A5) begin miscompares++; $display("FAIL bp_rsp_entry: valid=%b I=%h want 1 5A5", rsp_valid, rsp_I); end
        for (int c = 0; c < 4; c++) begin
            tick();
            core_done = 1'b1;
            core_Iout = 12'h111;
            core_Qout = 12'h222;
            #1;
            vectors++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_I !== 12'h5A5 || rsp_Q !== 12'hA5A) begin miscompares++; $display("FAIL bp_hold%0d: valid=%b id=%0d I=%h Q=%h want 1 1 5A5 A5A", c, rsp_valid, rsp_id, rsp_I, rsp_Q); end
            vectors++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin miscompares++; $display("FAIL bp_stall%0d: ready=%b busy=%b want 0000 1", c, req_ready, busy); end
        end
        core_done = 1'b0;
        tick();
        rsp_ready = 1'b1;
        #1;
        vectors++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_handshake: valid=%b ready=%b want 1 0000", rsp_valid, req_ready); end
        tick();
        rsp_ready = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0100) begin miscompares++; $display("FAIL bp_release: valid=%b busy=%b ready=%b want 0 0 0100", rsp_valid, busy, req_ready); end
        $display("backpressure: response held for 5 cycles, next grant ready=%b", req_ready);
    endtask

    task automatic test_timeout();
        tick();
        req_valid = '0;
        #1;
        vectors++; if (core_start !== 1'b1 || core_I !== 12'h021) begin miscompares++; $display("FAIL tmo_issue: start=%b I=%h want 1 021", core_start, core_I); end
        tick();
        #1;
        for (int c = 1; c <= TMO + 1; c++) begin
            tick();
            #1;
            vectors++; if (tmo_err !== (c == TMO) || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL tmo_cycle%0d: tmo_err=%b rsp_valid=%b want %b 0", c, tmo_err, rsp_valid, (c == TMO)); end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tmo_idle: busy %b want 0", busy); end
        req_valid = '1;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL tmo_next_grant: req_ready %b want 1000", req_ready); end
        $display("timeout: tmo_err after %0d WAIT cycles, next grant ready=%b", TMO, req_ready);
        // Done arriving in the very cycle the watchdog would fire takes priority.
        tick();
        req_valid = '0;
        #1;
        tick();
        #1;
        for (int c = 1; c <= TMO - 2; c++) tick();
        tick();
        core_done = 1'b1;
        core_Iout = 12'h007;
        core_Qout = 12'hFF9;
        #1;
        tick();
        core_done = 1'b0;
        #1;
        vectors++; if (tmo_err !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 2'd3) begin miscompares++; $display("FAIL tmo_done_wins: tmo=%b valid=%b id=%0d want 0 1 3", tmo_err, rsp_valid, rsp_id); end
        vectors++; if (rsp_I !== 12'h007 || rsp_Q !== 12'hFF9) begin miscompares++; $display("FAIL tmo_done_data: I=%h Q=%h want 007 FF9", rsp_I, rsp_Q); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || tmo_err !== 1'b0) begin miscompares++; $display("FAIL tmo_done_close: valid=%b tmo=%b want 0 0", rsp_valid, tmo_err); end
        $display("timeout: core_done on the last watchdog cycle produced a response");
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 4'b0010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rmw_grant: req_ready %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        tick();
        #1;
        vectors++; if (busy !== 1'b1 || core_start !== 1'b0) begin miscompares++; $display("FAIL rmw_wait: busy=%b start=%b want 1 0", busy, core_start); end
        rst = 1'b1;
        tick();
        #1;
        vectors++; if ({busy, rsp_valid, core_start, tmo_err} !== 4'b0 || {core_I, rsp_id} !== '0) begin miscompares++; $display("FAIL rmw_reset: ctrl=%b I=%h id=%0d want 0", {busy, rsp_valid, core_start, tmo_err}, core_I, rsp_id); end
        rst = 1'b0;
        core_done = 1'b1;
        core_Iout = 12'h123;
        tick();
        core_done = 1'b0;
        #1;
        vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_I !== 12'h000) begin miscompares++; $display("FAIL rmw_stray_done: valid=%b busy=%b I=%h want 0 0 000", rsp_valid, busy, rsp_I); end
        req_valid = 4'b1010;
        #1;
        vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL rmw_next_grant: req_ready %b want 0010", req_ready); end
        req_valid = '0;
        $display("reset_mid_wait: stray done ignored, grant restarts from ch1");
    endtask

    task automatic test_boundary();
        req_I[3*BW +: BW]       = 12'h7FF;
        req_Q[3*BW +: BW]       = 12'h800;
        req_phase[3*ABW +: ABW] = 10'h3FF;
        req_valid = 4'b1000;
        #1;
        vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bnd_grant: req_ready %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        #1;
        vectors++; if (core_I !== 12'h7FF || core_Q !== 12'h800 || core_phase !== 10'h3FF) begin miscompares++; $display("FAIL bnd_ops: I=%h Q=%h ph=%h want 7FF 800 3FF", core_I, core_Q, core_phase); end
        tick();
        core_done = 1'b1;
        core_Iout = 12'h7FF;
        core_Qout = 12'h800;
        #1;
        tick();
        core_done = 1'b0;
        #1;
        vectors++; if (rsp_I !== 12'h7FF || rsp_Q !== 12'h800 || rsp_id !== 2'd3) begin miscompares++; $display("FAIL bnd_rsp: I=%h Q=%h id=%0d want 7FF 800 3", rsp_I, rsp_Q, rsp_id); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = '1;
        #1;
        vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL bnd_ptr_wrap: req_ready %b want 0001", req_ready); end
        req_valid = '0;
        $display("boundary: ch3 I=2047 Q=-2048 ph=1023 passed through, ptr wrapped");
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_I     = '0;
        req_Q     = '0;
        req_phase = '0;
        core_done = 1'b0;
        core_Iout = '0;
        core_Qout = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish within 100000 time units");
        $fatal(1, "bench timeout");
    end

endmodule
